// File: rtl/restador_serie.sv
// rtl/restador_serie.sv - bit-serial N-bit subtractor, LSB first, registered {borrow, diff} result
// Optional signed-overflow flag ovf_o under macro RESTADOR_OVF_EN.
module restador_serie #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
`ifdef RESTADOR_OVF_EN
   output logic         ovf_o,
`endif
   output logic [N:0]   res_o,
   output logic         busy_o,
   output logic         done_o
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESTA = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t          state_q;
   logic [N-1:0]    a_q, b_q, diff_q;
   logic [CW-1:0]   cnt_q;
   logic            br_q;

   logic            d_bit;
   logic            br_d;
   logic [N-1:0]    diff_d;

   // One full-subtractor slice; a_q[0]/b_q[0] hold the operand MSBs on the last bit.
   always_comb begin
      d_bit  = a_q[0] ^ b_q[0] ^ br_q;
      br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      diff_d = {d_bit, diff_q[N-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         res_o   <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
`ifdef RESTADOR_OVF_EN
         ovf_o   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  busy_o  <= 1'b1;
                  state_q <= RESTA;
               end
            end
            RESTA: begin
               diff_q <= diff_d;
               br_q   <= br_d;
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(N - 1)) begin
                  res_o   <= {br_d, diff_d};
`ifdef RESTADOR_OVF_EN
                  ovf_o   <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
`endif
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  state_q <= FIN;
               end
            end
            FIN: begin
               done_o  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_restador_serie.sv
// tb/tb_restador_serie.sv - directed and table-driven checks for restador_serie (N=4)
module tb_restador_serie;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a_in, b_in;
   logic [4:0] res;
   logic       busy, done;
`ifdef RESTADOR_OVF_EN
   logic       ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   restador_serie #(.N(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .a_i     (a_in),
      .b_i     (b_in),
`ifdef RESTADOR_OVF_EN
      .ovf_o   (ovf),
`endif
      .res_o   (res),
      .busy_o  (busy),
      .done_o  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] exp_res;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] er, input logic eovf);
      int lat;
      lat = 0;
      start = 1'b1; a_in = a; b_in = b;
      tick();
      start = 1'b0; a_in = ~a; b_in = b ^ 4'h5;
      chk("busy_after_accept", int'(busy), 1);
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk("done_latency", lat, 4);
      chk("res", int'(res), int'(er));
      chk("busy_at_done", int'(busy), 0);
`ifdef RESTADOR_OVF_EN
      chk("ovf", int'(ovf), int'(eovf));
`else
      if (eovf !== 1'b0 && eovf !== 1'b1) chk("eovf_known", 0, 1);
`endif
      tick();
      chk("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      int dones, first_t, second_t;
      logic [4:0] er;

      vecs[0] = '{4'd4,  4'd5,  5'b11111};
      vecs[1] = '{4'd9,  4'd5,  5'b00100};
      vecs[2] = '{4'd4,  4'd7,  5'b11101};
      vecs[3] = '{4'd4,  4'd11, 5'b11001};
      vecs[4] = '{4'd3,  4'd15, 5'b10100};
      vecs[5] = '{4'd12, 4'd11, 5'b00001};

      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
      tick(); tick();
      chk("reset_res", int'(res), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst = 1'b0;

      // Each op starts on the cycle after the previous done.
      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_res, 1'b0);

      // start held high: one done every N+2 cycles.
      start = 1'b1; a_in = 4'd15; b_in = 4'd0;
      dones = 0; first_t = -1; second_t = -1;
      for (int t = 1; t <= 14; t++) begin
         tick();
         if (done) begin
            dones++;
            chk("held_res", int'(res), 5'b01111);
            if (first_t < 0) first_t = t;
            else if (second_t < 0) second_t = t;
         end
      end
      start = 1'b0;
      chk("held_done_count", dones, 2);
      chk("held_spacing", second_t - first_t, 6);
      tick(); tick(); tick(); tick(); tick();

      // Reset on E2 drops the operation.
      start = 1'b1; a_in = 4'd12; b_in = 4'd11;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_res", int'(res), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      dones = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (done) dones++;
      end
      chk("abort_no_done", dones, 0);
      run_op(4'd15, 4'd15, 5'b00000, 1'b0);

      // rst and start on the same edge: rst wins.
      rst = 1'b1; start = 1'b1; a_in = 4'd1; b_in = 4'd2;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rst_wins_busy", int'(busy), 0);

`ifdef RESTADOR_OVF_EN
      run_op(4'b0111, 4'b1000, 5'b11111, 1'b1);
      run_op(4'b0100, 4'b0101, 5'b11111, 1'b0);
      run_op(4'b0111, 4'b1000, 5'b11111, 1'b1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_clears_ovf", int'(ovf), 0);
`endif

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            er = 5'(a) - 5'(b);
            run_op(4'(a), 4'(b), er,
                   (a[3] ^ b[3]) & (a[3] ^ er[3]));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
